// File: rtl/pwm_bank.sv
// Bank of independent PWM channels whose duty is stepped up/down by debounced
// push buttons; duty changes are applied only at period boundaries.
module pwm_bank #(
   parameter int                          NUM_CH         = 3,
   parameter int                          CNT_W          = 19,
   parameter logic [NUM_CH*CNT_W-1:0]     PERIOD_VEC     = {19'd240000, 19'd24000, 19'd240000},
   parameter logic [NUM_CH*CNT_W-1:0]     STEP_VEC       = {19'd6000, 19'd600, 19'd6000},
   parameter logic [NUM_CH*CNT_W-1:0]     INIT_VEC       = {19'd60000, 19'd6000, 19'd60000},
   parameter int                          DEBOUNCE_TICKS = 3000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH-1:0]         inc_btn,
   input  logic [NUM_CH-1:0]         dec_btn,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic [NUM_CH*CNT_W-1:0]   duty_out,
   output logic [NUM_CH-1:0]         sat_flag
);

   localparam int                TICK_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
   localparam int                NB        = 2 * NUM_CH;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b,
                                                input logic [CNT_W-1:0] lim);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, lim}) ? lim : sum[CNT_W-1:0];
   endfunction

   // The extra top bit acts as the borrow when b exceeds a.
   function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      return diff[CNT_W] ? '0 : diff[CNT_W-1:0];
   endfunction

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              tick_p1;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         tick_p1  <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         tick_p1  <= tick;
      end
   end

   // Stage p0/p1: two-flop synchronizer, bits [NUM_CH-1:0] inc, upper half dec
   logic [NB-1:0] btn_p0, btn_p1;
   logic [NB-1:0] btn_cur, btn_prev, rel_seen;
   logic [NB-1:0] press;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_p0   <= '0;
         btn_p1   <= '0;
         btn_cur  <= '0;
         btn_prev <= '0;
         rel_seen <= '0;
      end else begin
         btn_p0 <= {dec_btn, inc_btn};
         btn_p1 <= btn_p0;
         if (tick) begin
            btn_cur  <= btn_p1;
            btn_prev <= btn_cur;
            rel_seen <= rel_seen | ~btn_p1;
         end
      end
   end

   // A button held through reset must be seen released before it can press.
   assign press = {NB{tick_p1}} & btn_cur & ~btn_prev & rel_seen;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] PER      = PERIOD_VEC[i*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] STP      = STEP_VEC[i*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] INI      = INIT_VEC[i*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] PER_LAST = PER - ONE;

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] target;
      logic [CNT_W-1:0] duty;
      logic             pwm_r;
      logic             inc_p, dec_p, wrap;

      assign inc_p = press[i];
      assign dec_p = press[NUM_CH+i];
      assign wrap  = (cnt == PER_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= '0;
            target <= INI;
            duty   <= INI;
            pwm_r  <= 1'b0;
         end else begin
            cnt <= wrap ? '0 : cnt + ONE;
            if (inc_p && !dec_p)
               target <= sat_add(target, STP, PER);
            else if (dec_p && !inc_p)
               target <= sat_sub(target, STP);
            if (wrap)
               duty <= target;
            pwm_r <= (cnt < duty) && ch_en[i];
         end
      end

      assign pwm_out[i]                  = pwm_r;
      assign duty_out[i*CNT_W +: CNT_W]  = duty;
      assign sat_flag[i]                 = (target == '0) || (target == PER);
   end

endmodule
